// File: rtl/sprite_animator_if.sv
// Sprite animator bus: frame-rate control in, sprite position and frame
// selection out. The master drives frame_tick and motion; the slave drives
// the sprite outputs.
interface sprite_animator_if;
  logic        frame_tick;
  logic [3:0]  motion;
  logic [10:0] SpriteX;
  logic [10:0] SpriteY;
  logic [3:0]  sel;
  logic        mirror;
  logic        blocked;

  modport master (
    output frame_tick, motion,
    input  SpriteX, SpriteY, sel, mirror, blocked
  );

  modport slave (
    input  frame_tick, motion,
    output SpriteX, SpriteY, sel, mirror, blocked
  );
endinterface

// File: rtl/sprite_animator.sv
// Sprite animator: walks a sprite horizontally between two bounds, sequences
// the walk animation frames and inserts a fixed-length turn pose whenever
// the requested direction changes. All updates are qualified by frame_tick.
//
// state | meaning
// IDLE  | standing still, sel=0, follows requested facing
// WALK  | stepping STEP pixels per tick, sel=1+anim
// TURN  | turn pose for FRAME_DIV ticks, sel=5, motion ignored until last tick
module sprite_animator #(
  parameter int X_START   = 290,
  parameter int Y_START   = 350,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 608,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  sprite_animator_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WALK, TURN} state_t;

  localparam logic [1:0]  LAST   = 2'(FRAME_DIV - 1);
  localparam logic [10:0] XSTART = 11'(X_START);
  localparam logic [10:0] YSTART = 11'(Y_START);
  localparam logic [10:0] XMIN   = 11'(X_MIN);
  localparam logic [10:0] XMAX   = 11'(X_MAX);
  localparam logic [10:0] XSTEP  = 11'(STEP);

  state_t      state_q, state_d;
  logic        facing_q, facing_d;
  logic [1:0]  div_q, div_d;
  logic [1:0]  anim_q, anim_d;
  logic [1:0]  tcnt_q, tcnt_d;
  logic [10:0] x_q, x_d;
  logic        blocked_q, blocked_d;
  logic [3:0]  sel_q, sel_d;

  logic        dir, walk;
  logic        unused_rsvd;
  logic [11:0] right_sum;
  logic [10:0] step_x;
  logic        step_blk;

  assign dir         = bus.motion[0];
  assign walk        = bus.motion[1];
  assign unused_rsvd = ^bus.motion[3:2];

  // One step in the requested direction, clamped at the bounds; the left
  // case compares before subtracting so it never wraps below zero.
  always_comb begin
    right_sum = {1'b0, x_q} + {1'b0, XSTEP};
    step_x    = x_q;
    step_blk  = 1'b0;
    if (dir) begin
      if (x_q < XMIN + XSTEP) begin
        step_x   = XMIN;
        step_blk = 1'b1;
      end else begin
        step_x   = x_q - XSTEP;
      end
    end else begin
      if (right_sum > {1'b0, XMAX}) begin
        step_x   = XMAX;
        step_blk = 1'b1;
      end else begin
        step_x   = right_sum[10:0];
      end
    end
  end

  // Next-state and next-output decode; everything holds unless a rule fires.
  always_comb begin
    state_d   = state_q;
    facing_d  = facing_q;
    div_d     = div_q;
    anim_d    = anim_q;
    tcnt_d    = tcnt_q;
    x_d       = x_q;
    blocked_d = blocked_q;

    if (state_q == WALK) begin
      if (!walk) begin
        state_d   = IDLE;
        blocked_d = 1'b0;
      end else if (dir != facing_q) begin
        state_d  = TURN;
        facing_d = dir;
        tcnt_d   = 2'd0;
      end else begin
        x_d       = step_x;
        blocked_d = step_blk;
        if (div_q == LAST) begin
          div_d  = 2'd0;
          anim_d = anim_q + 2'd1;
        end else begin
          div_d  = div_q + 2'd1;
        end
      end
    end else if (state_q == TURN && tcnt_q != LAST) begin
      tcnt_d = tcnt_q + 2'd1;
    end else begin
      // IDLE, or the final tick of TURN, which behaves exactly like IDLE
      if (!walk) begin
        state_d   = IDLE;
        facing_d  = dir;
        blocked_d = 1'b0;
      end else if (dir == facing_q) begin
        state_d   = WALK;
        anim_d    = 2'd0;
        div_d     = 2'd0;
        x_d       = step_x;
        blocked_d = step_blk;
      end else begin
        state_d  = TURN;
        facing_d = dir;
        tcnt_d   = 2'd0;
      end
    end

    case (state_d)
      WALK:    sel_d = {2'b00, anim_d} + 4'd1;
      TURN:    sel_d = 4'd5;
      default: sel_d = 4'd0;
    endcase
  end

  // State and output registers; synchronous reset wins over frame_tick.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= IDLE;
      facing_q  <= 1'b0;
      div_q     <= 2'd0;
      anim_q    <= 2'd0;
      tcnt_q    <= 2'd0;
      x_q       <= XSTART;
      blocked_q <= 1'b0;
      sel_q     <= 4'd0;
    end else if (bus.frame_tick) begin
      state_q   <= state_d;
      facing_q  <= facing_d;
      div_q     <= div_d;
      anim_q    <= anim_d;
      tcnt_q    <= tcnt_d;
      x_q       <= x_d;
      blocked_q <= blocked_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.SpriteX = x_q;
  assign bus.SpriteY = YSTART;
  assign bus.sel     = sel_q;
  assign bus.mirror  = facing_q;
  assign bus.blocked = blocked_q;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed bench for sprite_animator: a vector table run from reset, then
// hand-written sequences for animation timing, turns, bounds and reset.
module tb_sprite_animator;

  logic Clk;
  logic Reset;
  sprite_animator_if bus ();

  int checks;
  int errors;

  sprite_animator dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n;
    logic        ft;
    logic [3:0]  motion;
    logic [10:0] x;
    logic [3:0]  sel;
    logic        mirror;
    logic        blocked;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int x, input int sel,
                           input int mir, input int blk);
    check({name, ".SpriteX"}, int'(bus.SpriteX), x);
    check({name, ".SpriteY"}, int'(bus.SpriteY), 350);
    check({name, ".sel"},     int'(bus.sel),     sel);
    check({name, ".mirror"},  int'(bus.mirror),  mir);
    check({name, ".blocked"}, int'(bus.blocked), blk);
  endtask

  // drive inputs at the falling edge, sample 1ns after the rising edge
  task automatic apply(input logic rst_n, input logic ft, input logic [3:0] m);
    @(negedge Clk);
    Reset          = rst_n;
    bus.frame_tick = ft;
    bus.motion     = m;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    apply(1'b0, 1'b0, 4'b0000);
    apply(1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.frame_tick = 1'b0;
    bus.motion = 4'b0000;

    //         rst   ft    motion   x     sel  mir   blk
    vecs[0]  = '{1'b0, 1'b0, 4'b0000, 290, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'b0010, 290, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'b0010, 290, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'b0010, 292, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'b0010, 294, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'b0011, 294, 1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'b1110, 296, 1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'b0010, 298, 1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'b0010, 300, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'b0000, 300, 0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'b0001, 300, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'b0011, 298, 1, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'b0010, 298, 5, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 4'b0000, 298, 5, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'b0001, 298, 5, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'b0001, 298, 5, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 4'b0001, 298, 0, 1'b1, 1'b0};

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].rst_n, vecs[i].ft, vecs[i].motion);
      check_out($sformatf("vec%0d", i), int'(vecs[i].x), int'(vecs[i].sel),
                int'(vecs[i].mirror), int'(vecs[i].blocked));
    end

    // animation cadence: FRAME_DIV ticks per frame index
    do_reset();
    check_out("rst_pulse", 290, 0, 0, 0);
    for (int t = 1; t <= 8; t++) begin
      apply(1'b1, 1'b1, 4'b0010);
      check($sformatf("walk_t%0d.sel", t), int'(bus.sel), (t <= 4) ? 1 : 2);
      check($sformatf("walk_t%0d.x", t), int'(bus.SpriteX), 290 + 2 * t);
    end
    check_out("walk8", 306, 2, 0, 0);

    // turn from right to left mid-walk: X frozen for FRAME_DIV ticks
    for (int t = 1; t <= 4; t++) begin
      apply(1'b1, 1'b1, 4'b0011);
      check_out($sformatf("turn_t%0d", t), 306, 5, 1, 0);
    end
    apply(1'b1, 1'b1, 4'b0011);
    check_out("turn_exit", 304, 1, 1, 0);

    // right bound clamp, then left bound clamp from X_MAX down to 0
    do_reset();
    for (int t = 1; t <= 159; t++) apply(1'b1, 1'b1, 4'b0010);
    check("rb159.x", int'(bus.SpriteX), 608);
    check("rb159.blocked", int'(bus.blocked), 0);
    apply(1'b1, 1'b1, 4'b0010);
    check("rb160.x", int'(bus.SpriteX), 608);
    check("rb160.blocked", int'(bus.blocked), 1);
    apply(1'b1, 1'b1, 4'b0000);
    check_out("rb_stop", 608, 0, 0, 0);
    apply(1'b1, 1'b1, 4'b0001);
    check_out("face_left", 608, 0, 1, 0);
    for (int t = 1; t <= 304; t++) apply(1'b1, 1'b1, 4'b0011);
    check("lb304.x", int'(bus.SpriteX), 0);
    check("lb304.blocked", int'(bus.blocked), 0);
    apply(1'b1, 1'b1, 4'b0011);
    check("lb305.x", int'(bus.SpriteX), 0);
    check("lb305.blocked", int'(bus.blocked), 1);

    // facing change in IDLE, then no frame_tick: nothing may move
    do_reset();
    apply(1'b1, 1'b1, 4'b0001);
    check_out("idle_face", 290, 0, 1, 0);
    for (int c = 0; c < 20; c++) begin
      apply(1'b1, 1'b0, 4'b1110);
      check_out($sformatf("hold_c%0d", c), 290, 0, 1, 0);
    end

    // reset on the second tick of TURN discards all turn state
    do_reset();
    apply(1'b1, 1'b1, 4'b0011);
    check_out("mid_turn", 290, 5, 1, 0);
    apply(1'b0, 1'b1, 4'b0011);
    check_out("turn_reset", 290, 0, 0, 0);
    apply(1'b1, 1'b1, 4'b0010);
    check_out("after_reset_walk", 292, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameters SHALL be: X_START 290 (reset X); Y_START 350 (fixed Y); X_MIN 0 (left bound); X_MAX 608 (right bound); STEP 2 (pixels per walk tick); FRAME_DIV 4 (ticks per animation step and per turn).
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; sampled on Clk rising edge.
REQ-004 frame_tick  input  1  one-cycle pulse per video frame; qualifies every update.
REQ-005 motion  input  4  from sprite state stage: bit0 dir (1=left, 0=right), bit1 walk (1=walking), bits3:2 reserved and ignored.
REQ-006 SpriteX  output  11  sprite left-edge X, unsigned.
REQ-007 SpriteY  output  11  sprite top-edge Y; constant Y_START.
REQ-008 sel  output  4  sprite ROM frame index.
REQ-009 mirror  output  1  horizontal flip; 1 = facing left.
REQ-010 blocked  output  1  last walk step was clamped at a bound.

Function
REQ-011 All outputs SHALL be registered; state, counters and outputs SHALL change only on Clk edges with frame_tick=1; with frame_tick=0 everything SHALL hold.
REQ-012 motion SHALL be sampled only on frame_tick edges; result visible the cycle after that edge.
REQ-013 FSM states SHALL be IDLE, WALK, TURN; internal regs: facing (1 bit), div (2 bits, 0..FRAME_DIV-1), anim (2 bits), tcnt (2 bits).
REQ-014 IDLE, walk=0: facing <= dir; stay IDLE; X holds; blocked <= 0.
REQ-015 IDLE, walk=1, dir==facing: enter WALK; anim<=0, div<=0; perform one step (REQ-018) on the same tick.
REQ-016 IDLE, walk=1, dir!=facing: enter TURN; facing <= dir; tcnt<=0; X holds.
REQ-017 WALK: walk=0 -> IDLE, X holds, blocked<=0; walk=1, dir!=facing -> TURN as REQ-016; walk=1, dir==facing -> step; if div==FRAME_DIV-1 then div<=0, anim<=anim+1 (wraps 3->0) else div<=div+1.
REQ-018 Step: right X<=min(X+STEP, X_MAX); left X<=max(X-STEP, X_MIN), computed without underflow; blocked<=1 iff unclamped result would lie beyond bound, else 0.
REQ-019 TURN: motion ignored and X held while tcnt<FRAME_DIV-1 (tcnt increments); at tcnt==FRAME_DIV-1 evaluate motion exactly as IDLE (REQ-014..016), so TURN occupies FRAME_DIV ticks minimum.
REQ-020 sel SHALL be 0 in IDLE, 1+anim in WALK (1..4), 5 in TURN; values 6..15 never driven.
REQ-021 mirror SHALL equal facing; SpriteY SHALL always equal Y_START.
REQ-022 Reserved motion bits SHALL have no effect on any output.

Reset
REQ-023 Reset=0 on a Clk edge SHALL set, regardless of frame_tick or state: state IDLE, SpriteX=X_START, SpriteY=Y_START, sel=0, mirror=0, blocked=0, facing=0, div=0, anim=0, tcnt=0.
REQ-024 Reset asserted mid-WALK or mid-TURN SHALL abandon that operation with no residual counter state.

Verification
REQ-025 Reset pulse low 2 cycles -> SpriteX=290, SpriteY=350, sel=0, mirror=0, blocked=0.
REQ-026 motion=4'b0010, 8 frame_ticks -> SpriteX=306; sel=1 after ticks 1-4, sel=2 after ticks 5-8; mirror=0.
REQ-027 Walking right, then motion=4'b0011 -> sel=5, mirror=1, X frozen for 4 ticks; 5th tick sel=1, X decreases by 2.
REQ-028 motion=4'b0010 for 160 ticks from reset -> SpriteX=608 after tick 159 with blocked=0; tick 160 SpriteX=608, blocked=1; motion=4'b0000 next tick -> blocked=0, sel=0.
REQ-029 motion=4'b0001 in IDLE for 1 tick -> mirror=1, sel=0, X unchanged; motion=4'b1110 with frame_tick held 0 for 20 cycles -> no output change.
REQ-030 Reset=0 on 2nd tick of TURN -> next cycle all outputs equal REQ-025 values; motion=4'b0010 afterwards -> WALK entry with X=292, sel=1.
